// File: rtl/wb_pwm_led.sv
// wb_pwm_led: multi-channel Wishbone-mapped PWM LED controller.
// Programmable prescaler, per-channel duty/enable, duty changes applied only
// at the PWM period boundary. Hardware breathing is built only when the macro
// WB_PWM_LED_BREATHE_EN is defined; otherwise the breathe bits read 0.
module wb_pwm_led #(
  parameter int N_CH    = 3,
  parameter int PWM_W   = 8,
  parameter int PRESC_W = 16,
  parameter int ADDR_W  = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [ADDR_W-1:0] wb_addr,
  input  logic [31:0]       wb_wdata,
  input  logic [3:0]        wb_wstb,
  input  logic              wb_we,
  input  logic              wb_cyc,
  input  logic              wb_stb,
  output logic [31:0]       wb_rdata,
  output logic              wb_ack,
  output logic [N_CH-1:0]   pwm_o,
  output logic              period_o
);

  localparam logic [PWM_W-1:0] CNT_MAX = '1;

  logic               req;
  logic               wr;
  logic [31:0]        wmask;
  logic [31:0]        rd_mux;
  logic               unused_bits;

  logic               gen;
  logic [N_CH-1:0]    ch_en;
  logic [PRESC_W-1:0] presc;
  logic [PWM_W-1:0]   duty [N_CH];

  logic [PRESC_W-1:0] presc_cnt;
  logic [PWM_W-1:0]   cnt;
  logic               tick;
  logic               wrap;
  logic [PWM_W-1:0]   active [N_CH];
  logic [PWM_W-1:0]   eff [N_CH];
  logic [N_CH-1:0]    pwm_next;

`ifdef WB_PWM_LED_BREATHE_EN
  logic [N_CH-1:0]    br_en;
  logic [N_CH-1:0]    br_act;
  logic [N_CH-1:0]    ramp_down;
  logic [N_CH-1:0]    down_nxt;
  logic [PWM_W-1:0]   ramp [N_CH];
  logic [PWM_W-1:0]   ramp_nxt [N_CH];
`endif

  assign req   = wb_cyc & wb_stb & ~wb_ack;
  assign wr    = req & wb_we;
  assign wmask = {{8{wb_wstb[3]}}, {8{wb_wstb[2]}}, {8{wb_wstb[1]}}, {8{wb_wstb[0]}}};
  assign unused_bits = ^{wb_wdata, wmask};

  assign tick = gen & (presc_cnt == '0);
  assign wrap = tick & (cnt == CNT_MAX);

  // Read data selection from the register map; unmapped words read 0
  always_comb begin
    rd_mux = '0;
    if (wb_addr == ADDR_W'(0)) begin
      rd_mux[0]         = gen;
      rd_mux[8 +: N_CH] = ch_en;
`ifdef WB_PWM_LED_BREATHE_EN
      rd_mux[16 +: N_CH] = br_en;
`endif
    end else if (wb_addr == ADDR_W'(1)) begin
      rd_mux[PRESC_W-1:0] = presc;
    end else if (wb_addr == ADDR_W'(2)) begin
      rd_mux[N_CH-1:0]    = pwm_o;
      rd_mux[16 +: PWM_W] = cnt;
    end
    for (int k = 0; k < N_CH; k++) begin
      if (wb_addr == ADDR_W'(4 + k)) rd_mux[PWM_W-1:0] = duty[k];
    end
  end

  // Single-cycle ack one clock after a new request; read data only during ack
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wb_ack   <= 1'b0;
      wb_rdata <= '0;
    end else begin
      wb_ack   <= req;
      wb_rdata <= (req && !wb_we) ? rd_mux : '0;
    end
  end

  // Register writes, merged per byte lane, committed on the edge raising ack
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      gen   <= 1'b0;
      ch_en <= '0;
      presc <= '0;
      for (int k = 0; k < N_CH; k++) duty[k] <= '0;
`ifdef WB_PWM_LED_BREATHE_EN
      br_en <= '0;
`endif
    end else if (wr) begin
      if (wb_addr == ADDR_W'(0)) begin
        if (wb_wstb[0]) gen <= wb_wdata[0];
        ch_en <= (ch_en & ~wmask[8 +: N_CH]) | (wb_wdata[8 +: N_CH] & wmask[8 +: N_CH]);
`ifdef WB_PWM_LED_BREATHE_EN
        br_en <= (br_en & ~wmask[16 +: N_CH]) | (wb_wdata[16 +: N_CH] & wmask[16 +: N_CH]);
`endif
      end
      if (wb_addr == ADDR_W'(1)) begin
        presc <= (presc & ~wmask[PRESC_W-1:0]) | (wb_wdata[PRESC_W-1:0] & wmask[PRESC_W-1:0]);
      end
      for (int k = 0; k < N_CH; k++) begin
        if (wb_addr == ADDR_W'(4 + k)) begin
          duty[k] <= (duty[k] & ~wmask[PWM_W-1:0]) | (wb_wdata[PWM_W-1:0] & wmask[PWM_W-1:0]);
        end
      end
    end
  end

  // Prescaler down-counter and PWM counter, both held at 0 while disabled
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      presc_cnt <= '0;
      cnt       <= '0;
      period_o  <= 1'b0;
    end else begin
      period_o <= wrap;
      if (!gen) begin
        presc_cnt <= '0;
        cnt       <= '0;
      end else if (tick) begin
        presc_cnt <= presc;
        cnt       <= cnt + PWM_W'(1);
      end else begin
        presc_cnt <= presc_cnt - PRESC_W'(1);
      end
    end
  end

  // Active duties follow DUTYk while disabled and are reloaded only at wrap
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < N_CH; k++) active[k] <= '0;
    end else if (!gen || wrap) begin
      for (int k = 0; k < N_CH; k++) active[k] <= duty[k];
    end
  end

`ifdef WB_PWM_LED_BREATHE_EN
  // Next ramp value: climb to DUTYk, then descend to 0, flipping at each bound
  always_comb begin
    down_nxt = ramp_down;
    for (int k = 0; k < N_CH; k++) begin
      ramp_nxt[k] = ramp[k];
      if (!ramp_down[k]) begin
        if (ramp[k] < duty[k]) begin
          ramp_nxt[k] = ramp[k] + PWM_W'(1);
        end else begin
          down_nxt[k] = 1'b1;
          ramp_nxt[k] = (ramp[k] == '0) ? '0 : ramp[k] - PWM_W'(1);
        end
      end else if (ramp[k] == '0) begin
        down_nxt[k] = 1'b0;
        ramp_nxt[k] = (duty[k] != '0) ? PWM_W'(1) : '0;
      end else begin
        ramp_nxt[k] = ramp[k] - PWM_W'(1);
      end
    end
  end

  // Ramp state steps once per period; br_act keeps a cleared channel ramping until wrap
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      br_act    <= '0;
      ramp_down <= '0;
      for (int k = 0; k < N_CH; k++) ramp[k] <= '0;
    end else begin
      if (!gen || wrap) br_act <= br_en;
      for (int k = 0; k < N_CH; k++) begin
        if (!gen || !(br_en[k] | br_act[k])) begin
          ramp[k]      <= '0;
          ramp_down[k] <= 1'b0;
        end else if (wrap && br_en[k]) begin
          ramp[k]      <= ramp_nxt[k];
          ramp_down[k] <= down_nxt[k];
        end
      end
    end
  end
`endif

  // Effective duty per channel and the comparator feeding the output register
  always_comb begin
    for (int k = 0; k < N_CH; k++) begin
      eff[k] = active[k];
`ifdef WB_PWM_LED_BREATHE_EN
      if (br_en[k] | br_act[k]) eff[k] = ramp[k];
`endif
      pwm_next[k] = gen & ch_en[k] & (cnt < eff[k]);
    end
  end

  // Registered PWM outputs, one clock behind the counter
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pwm_o <= '0;
    end else begin
      pwm_o <= pwm_next;
    end
  end

endmodule
